rv_decode_execute: RTL and testbench

- Combined RV32I decode, control-generation and execute (ALU) stage for the in-order pipeline.
- Takes the instruction from the fetch/decode register and the two register-file read values.
- Decodes fields and generates control signals combinationally, computes the ALU result, then registers the result and controls into the execute/memory boundary with 1-cycle latency.

---
 rtl/rv_pkg.sv | 44 ++++
 rtl/rv_alu.sv | 58 +++++
 rtl/rv_decode_execute.sv | 122 ++++++++++++
 tb/tb_rv_decode_execute.sv | 128 ++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: opcodes, operand-select enum, funct3 codes, control bundle.
package rv_pkg;
   localparam int XLEN = 32;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {
      SEL_RS2    = 2'd0,
      SEL_I_SEXT = 2'd1,
      SEL_I_ZEXT = 2'd2,
      SEL_S_SEXT = 2'd3
   } imm_sel_e;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic branch;
      logic jump;
   } ctrl_t;
endpackage

// File: rtl/rv_alu.sv
// Combinational RV32I ALU; branches produce 0 when the condition holds so zero means taken.
module rv_alu
   import rv_pkg::*;
(
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   output logic [XLEN-1:0] result,
   output logic            zero
);
   logic br_cond;
   logic unused_f7;

   assign unused_f7 = ^{funct7[6], funct7[4:0]};

   always_comb begin
      br_cond = 1'b0;
      case (funct3)
         F3_BEQ:  br_cond = (op1 == op2);
         F3_BNE:  br_cond = (op1 != op2);
         F3_BLT:  br_cond = ($signed(op1) < $signed(op2));
         F3_BGE:  br_cond = ($signed(op1) >= $signed(op2));
         F3_BLTU: br_cond = (op1 < op2);
         F3_BGEU: br_cond = (op1 >= op2);
         default: br_cond = 1'b0;
      endcase
   end

   always_comb begin
      result = '0;
      case (opcode)
         OP_R, OP_IMM: begin
            case (funct3)
               // ADDI never subtracts: its funct7 bits are immediate bits
               F3_ADD:  result = (opcode == OP_R && funct7[5]) ? op1 - op2 : op1 + op2;
               F3_SLL:  result = op1 << op2[4:0];
               F3_SLT:  result = {31'b0, $signed(op1) < $signed(op2)};
               F3_SLTU: result = {31'b0, op1 < op2};
               F3_XOR:  result = op1 ^ op2;
               F3_SR: begin
                  if (funct7[5]) result = $signed(op1) >>> op2[4:0];
                  else           result = op1 >> op2[4:0];
               end
               F3_OR:   result = op1 | op2;
               F3_AND:  result = op1 & op2;
               default: result = '0;
            endcase
         end
         OP_LOAD, OP_STORE: result = op1 + op2;
         OP_BRANCH:         result = {31'b0, ~br_cond};
         default:           result = '0;
      endcase
   end

   assign zero = (result == '0);
endmodule

// File: rtl/rv_decode_execute.sv
// RV32I decode + control + ALU with a single register stage into the execute/memory boundary.
module rv_decode_execute
   import rv_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int B_IMM_WIDTH    = 13
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [31:0]               instr,
   input  logic [DATA_WIDTH-1:0]     rs1_data,
   input  logic [DATA_WIDTH-1:0]     rs2_data,
   input  logic                      bubble,
   output logic [REG_ADDR_WIDTH-1:0] rs1_addr,
   output logic [REG_ADDR_WIDTH-1:0] rs2_addr,
   output logic [DATA_WIDTH-1:0]     ex_result,
   output logic                      ex_zero,
   output logic [REG_ADDR_WIDTH-1:0] ex_rd,
   output logic [DATA_WIDTH-1:0]     ex_store_data,
   output logic [B_IMM_WIDTH-1:0]    ex_b_imm,
   output logic                      ex_reg_write,
   output logic                      ex_mem_read,
   output logic                      ex_mem_write,
   output logic                      ex_mem_to_reg,
   output logic                      ex_branch,
   output logic                      ex_jump
);
   logic [6:0]                opcode;
   logic [REG_ADDR_WIDTH-1:0] rd;
   logic [2:0]                funct3;
   logic [6:0]                funct7;
   logic [11:0]               i_imm;
   logic [11:0]               s_imm;
   logic [B_IMM_WIDTH-1:0]    b_imm;
   imm_sel_e                  imm_sel;
   ctrl_t                     ctrl, ex_ctrl;
   logic [DATA_WIDTH-1:0]     op2, alu_result;
   logic                      alu_zero;

   assign opcode   = instr[6:0];
   assign rd       = instr[11:7];
   assign funct3   = instr[14:12];
   assign rs1_addr = instr[19:15];
   assign rs2_addr = instr[24:20];
   assign funct7   = instr[31:25];
   assign i_imm    = instr[31:20];
   assign s_imm    = {instr[31:25], instr[11:7]};
   assign b_imm    = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

   always_comb begin
      ctrl    = '0;
      imm_sel = SEL_RS2;
      case (opcode)
         OP_R:   ctrl.reg_write = 1'b1;
         OP_IMM: begin
            ctrl.reg_write = 1'b1;
            imm_sel = (funct3 == F3_SLL || funct3 == F3_SR) ? SEL_I_ZEXT : SEL_I_SEXT;
         end
         OP_LOAD: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            imm_sel         = SEL_I_SEXT;
         end
         OP_STORE: begin
            ctrl.mem_write = 1'b1;
            imm_sel        = SEL_S_SEXT;
         end
         OP_BRANCH:       ctrl.branch = 1'b1;
         OP_JAL, OP_JALR: ctrl.jump   = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      op2 = '0;
      case (imm_sel)
         SEL_RS2:    op2 = rs2_data;
         SEL_I_SEXT: op2 = {{20{i_imm[11]}}, i_imm};
         SEL_I_ZEXT: op2 = {20'b0, i_imm};
         SEL_S_SEXT: op2 = {{20{s_imm[11]}}, s_imm};
         default:    op2 = '0;
      endcase
   end

   rv_alu u_alu (
      .op1    (rs1_data),
      .op2    (op2),
      .opcode (opcode),
      .funct3 (funct3),
      .funct7 (funct7),
      .result (alu_result),
      .zero   (alu_zero)
   );

   // Bubble only kills controls; data still flows so the slot stays well-defined
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_result     <= '0;
         ex_zero       <= 1'b0;
         ex_rd         <= '0;
         ex_store_data <= '0;
         ex_b_imm      <= '0;
         ex_ctrl       <= '0;
      end else begin
         ex_result     <= alu_result;
         ex_zero       <= alu_zero;
         ex_rd         <= rd;
         ex_store_data <= rs2_data;
         ex_b_imm      <= b_imm;
         ex_ctrl       <= bubble ? '0 : ctrl;
      end
   end

   assign ex_reg_write  = ex_ctrl.reg_write;
   assign ex_mem_read   = ex_ctrl.mem_read;
   assign ex_mem_write  = ex_ctrl.mem_write;
   assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
   assign ex_branch     = ex_ctrl.branch;
   assign ex_jump       = ex_ctrl.jump;
endmodule

// File: tb/tb_rv_decode_execute.sv
// Directed vector bench for rv_decode_execute: table of hand-computed results plus reset sequences.
module tb_rv_decode_execute;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr, rs1_data, rs2_data;
   logic        bubble;
   logic [4:0]  rs1_addr, rs2_addr, ex_rd;
   logic [31:0] ex_result, ex_store_data;
   logic        ex_zero;
   logic [12:0] ex_b_imm;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_jump;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rv_decode_execute dut (
      .clk(clk), .rst(rst), .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .bubble(bubble), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .ex_result(ex_result),
      .ex_zero(ex_zero), .ex_rd(ex_rd), .ex_store_data(ex_store_data), .ex_b_imm(ex_b_imm),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_jump(ex_jump)
   );

   // ctrl order: reg_write, mem_read, mem_write, mem_to_reg, branch, jump
   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        bub;
      logic [31:0] res;
      logic        zero;
      logic [4:0]  rd;
      logic [5:0]  ctrl;
      logic        chk_bimm;
      logic [12:0] bimm;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [5:0] ctrl_now();
      return {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_jump};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, ".result"}, ex_result, 32'h0);
      chk({nm, ".zero"}, {31'b0, ex_zero}, 32'h0);
      chk({nm, ".rd"}, {27'b0, ex_rd}, 32'h0);
      chk({nm, ".store"}, ex_store_data, 32'h0);
      chk({nm, ".bimm"}, {19'b0, ex_b_imm}, 32'h0);
      chk({nm, ".ctrl"}, {26'b0, ctrl_now()}, 32'h0);
   endtask

   initial begin
      vecs.push_back('{"add",    32'h002081B3, 32'd5,        32'd7,        1'b0, 32'd12,       1'b0, 5'd3,  6'b100000, 1'b0, 13'h0});
      vecs.push_back('{"sub0",   32'h402081B3, 32'd9,        32'd9,        1'b0, 32'd0,        1'b1, 5'd3,  6'b100000, 1'b0, 13'h0});
      vecs.push_back('{"addi-1", 32'hFFF08093, 32'd1,        32'd0,        1'b0, 32'd0,        1'b1, 5'd1,  6'b100000, 1'b0, 13'h0});
      vecs.push_back('{"srai",   32'h4040D093, 32'h80000000, 32'd0,        1'b0, 32'hF8000000, 1'b0, 5'd1,  6'b100000, 1'b0, 13'h0});
      vecs.push_back('{"sltu",   32'h0020B1B3, 32'd1,        32'hFFFFFFFF, 1'b0, 32'd1,        1'b0, 5'd3,  6'b100000, 1'b0, 13'h0});
      vecs.push_back('{"slt",    32'h0020A1B3, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd1,        1'b0, 5'd3,  6'b100000, 1'b0, 13'h0});
      vecs.push_back('{"sll",    32'h002091B3, 32'd1,        32'h24,       1'b0, 32'h10,       1'b0, 5'd3,  6'b100000, 1'b0, 13'h0});
      vecs.push_back('{"srl",    32'h0020D1B3, 32'h80000000, 32'd4,        1'b0, 32'h08000000, 1'b0, 5'd3,  6'b100000, 1'b0, 13'h0});
      vecs.push_back('{"and",    32'h0020F1B3, 32'h0000F0F0, 32'h0000FF00, 1'b0, 32'h0000F000, 1'b0, 5'd3,  6'b100000, 1'b0, 13'h0});
      vecs.push_back('{"sw",     32'h0020A423, 32'h100,      32'hAB,       1'b0, 32'h108,      1'b0, 5'd8,  6'b001000, 1'b0, 13'h0});
      vecs.push_back('{"lw",     32'h0040A283, 32'h200,      32'h55,       1'b0, 32'h204,      1'b0, 5'd5,  6'b110100, 1'b0, 13'h0});
      vecs.push_back('{"bne",    32'hFE209EE3, 32'd3,        32'd4,        1'b0, 32'd0,        1'b1, 5'h1D, 6'b000010, 1'b1, 13'h1FFC});
      vecs.push_back('{"beq_nt", 32'hFE208EE3, 32'd3,        32'd4,        1'b0, 32'd1,        1'b0, 5'h1D, 6'b000010, 1'b1, 13'h1FFC});
      vecs.push_back('{"blt",    32'hFE20CEE3, 32'hFFFFFFFF, 32'd0,        1'b0, 32'd0,        1'b1, 5'h1D, 6'b000010, 1'b1, 13'h1FFC});
      vecs.push_back('{"bgeu",   32'hFE20FEE3, 32'hFFFFFFFF, 32'd0,        1'b0, 32'd0,        1'b1, 5'h1D, 6'b000010, 1'b1, 13'h1FFC});
      vecs.push_back('{"br010",  32'hFE20AEE3, 32'd3,        32'd3,        1'b0, 32'd1,        1'b0, 5'h1D, 6'b000010, 1'b1, 13'h1FFC});
      vecs.push_back('{"jal",    32'h000000EF, 32'd7,        32'd9,        1'b0, 32'd0,        1'b1, 5'd1,  6'b000001, 1'b1, 13'h0800});
      vecs.push_back('{"unk",    32'h0000007F, 32'd7,        32'h11,       1'b0, 32'd0,        1'b1, 5'd0,  6'b000000, 1'b0, 13'h0});
      vecs.push_back('{"nop",    32'h00000013, 32'd0,        32'd0,        1'b0, 32'd0,        1'b1, 5'd0,  6'b100000, 1'b0, 13'h0});
      vecs.push_back('{"bubble", 32'h002081B3, 32'd5,        32'd7,        1'b1, 32'd12,       1'b0, 5'd3,  6'b000000, 1'b0, 13'h0});

      rst = 1'b1; instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7; bubble = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk_all_zero("reset");
      chk("rs1_addr", {27'b0, rs1_addr}, 32'd1);
      chk("rs2_addr", {27'b0, rs2_addr}, 32'd2);

      @(negedge clk) rst = 1'b0;
      foreach (vecs[i]) begin
         @(negedge clk);
         instr = vecs[i].instr; rs1_data = vecs[i].rs1; rs2_data = vecs[i].rs2; bubble = vecs[i].bub;
         @(posedge clk);
         #1;
         chk({vecs[i].name, ".result"}, ex_result, vecs[i].res);
         chk({vecs[i].name, ".zero"}, {31'b0, ex_zero}, {31'b0, vecs[i].zero});
         chk({vecs[i].name, ".rd"}, {27'b0, ex_rd}, {27'b0, vecs[i].rd});
         chk({vecs[i].name, ".store"}, ex_store_data, vecs[i].rs2);
         chk({vecs[i].name, ".ctrl"}, {26'b0, ctrl_now()}, {26'b0, vecs[i].ctrl});
         if (vecs[i].chk_bimm)
            chk({vecs[i].name, ".bimm"}, {19'b0, ex_b_imm}, {19'b0, vecs[i].bimm});
      end

      // Output must hold the previous instruction until the edge (1-cycle latency)
      @(negedge clk);
      instr = 32'h0020A423; rs1_data = 32'h100; rs2_data = 32'hAB; bubble = 1'b0;
      #1 chk("latency.hold", ex_result, 32'd12);
      chk("latency.rs1_addr", {27'b0, rs1_addr}, 32'd1);
      @(posedge clk); #1 chk("latency.result", ex_result, 32'h108);

      // Reset mid-stream overrides bubble and new data
      @(negedge clk);
      rst = 1'b1; instr = 32'hFE209EE3; rs1_data = 32'd3; rs2_data = 32'd4; bubble = 1'b1;
      @(posedge clk); #1 chk_all_zero("midrst");
      @(negedge clk);
      rst = 1'b0; bubble = 1'b0;
      @(posedge clk); #1;
      chk("postrst.zero", {31'b0, ex_zero}, 32'd1);
      chk("postrst.branch", {31'b0, ex_branch}, 32'd1);
      chk("postrst.bimm", {19'b0, ex_b_imm}, 32'h1FFC);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
